uart_tx_arbiter: RTL

Shares the single UART transmitter between two requesters: register-file read data (1 byte) and ALU result (16 bits, sent as 2 bytes). It grants one requester at a time and captures its payload. It sequences each byte into the transmitter through the transmitter's data-valid/busy handshake. It sits between the system controller datapath and the UART TX top level, in the UART clock domain.

---
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Arbitrates a register-file byte and a 16-bit ALU result onto one UART
// transmitter, sequencing bytes through the transmitter's valid/busy handshake.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 8,
  parameter int TO_CNT_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rf_valid,
  input  logic [DATA_WIDTH-1:0]   rf_data,
  output logic                    rf_ready,
  input  logic                    alu_valid,
  input  logic [2*DATA_WIDTH-1:0] alu_data,
  output logic                    alu_ready,
  input  logic                    tx_busy,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_data_valid,
  output logic                    arb_busy,
  output logic                    tx_err,
  output logic [1:0]              fsm_state
);

  // Handshake: a request transfers in the cycle where valid && ready; ready is
  // only ever raised in IDLE with the transmitter free, and the requester must
  // hold valid and data stable until it sees ready.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t                  state, state_next;
  logic [2*DATA_WIDTH-1:0] hold, hold_next;
  logic [1:0]              bytes_left, bytes_left_next;
  logic                    last_alu, last_alu_next;
  logic [TO_CNT_W-1:0]     to_cnt, to_cnt_next;
  logic                    arb_busy_next;
  logic                    tx_err_next;
  logic                    grant_rf, grant_alu;

  // Round-robin only matters on a tie; last_alu tracks whoever was served last.
  always_comb begin
    grant_rf  = 1'b0;
    grant_alu = 1'b0;
    if (state == IDLE && !tx_busy) begin
      if (rf_valid && alu_valid) begin
        grant_rf  = last_alu;
        grant_alu = !last_alu;
      end else begin
        grant_rf  = rf_valid;
        grant_alu = alu_valid;
      end
    end
  end

  always_comb begin
    state_next      = state;
    hold_next       = hold;
    bytes_left_next = bytes_left;
    last_alu_next   = last_alu;
    to_cnt_next     = to_cnt;
    tx_err_next     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_rf) begin
          hold_next       = {{DATA_WIDTH{1'b0}}, rf_data};
          bytes_left_next = 2'd1;
          last_alu_next   = 1'b0;
          state_next      = LAUNCH;
        end else if (grant_alu) begin
          hold_next       = alu_data;
          bytes_left_next = 2'd2;
          last_alu_next   = 1'b1;
          state_next      = LAUNCH;
        end
      end
      LAUNCH: begin
        to_cnt_next = '0;
        state_next  = WAIT_HI;
      end
      WAIT_HI: begin
        // Counter runs 0..BUSY_TIMEOUT-1, so the error fires after exactly
        // BUSY_TIMEOUT cycles spent here without seeing busy.
        if (tx_busy) begin
          state_next = WAIT_LO;
        end else if (to_cnt == TO_CNT_W'(BUSY_TIMEOUT - 1)) begin
          tx_err_next     = 1'b1;
          bytes_left_next = '0;
          state_next      = IDLE;
        end else begin
          to_cnt_next = to_cnt + TO_CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          bytes_left_next = bytes_left - 2'd1;
          if (bytes_left == 2'd2) begin
            hold_next  = hold >> DATA_WIDTH;
            state_next = LAUNCH;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    arb_busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold       <= '0;
      bytes_left <= '0;
      last_alu   <= 1'b1;
      to_cnt     <= '0;
      arb_busy   <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      state      <= state_next;
      hold       <= hold_next;
      bytes_left <= bytes_left_next;
      last_alu   <= last_alu_next;
      to_cnt     <= to_cnt_next;
      arb_busy   <= arb_busy_next;
      tx_err     <= tx_err_next;
    end
  end

  // hold only changes on entry to LAUNCH, so the byte bus is stable otherwise.
  assign tx_data       = hold[DATA_WIDTH-1:0];
  assign tx_data_valid = (state == LAUNCH);
  assign rf_ready      = grant_rf;
  assign alu_ready     = grant_alu;
  assign fsm_state     = state;

endmodule
